// File: rtl/bp_be_stride_detector_pkg.sv
// bp_be_stride_detector_pkg: shared widths, training-entry struct and confidence helper for the stride detector
package bp_be_stride_detector_pkg;
  localparam int vaddr_width_gp = 39;
  localparam int dpath_width_gp = 64;
  localparam int stride_width_gp = 8;
  localparam int loop_range_gp = 8;
  localparam logic [1:0] conf_max_gp = 2'b11;
  typedef struct packed {
    logic valid;
    logic [vaddr_width_gp-1:0] tag;
    logic [dpath_width_gp-1:0] last_addr;
    logic [stride_width_gp-1:0] stride;
    logic [1:0] conf;
    logic issued;
    logic [loop_range_gp-1:0] cooldown;
  } bp_be_stride_entry_s;
  function automatic logic [1:0] conf_inc(input logic [1:0] c);
    return (c == conf_max_gp) ? c : c + 2'd1;
  endfunction
endpackage

// File: rtl/bp_be_stride_detector_entry.sv
// bp_be_stride_detector_entry: one PC-tagged training entry
//   ports: clk_i, reset_i, flush_i; obs_v_i/obs_pc_i/obs_eff_addr_i observed load;
//   alloc_i overwrite this entry on a table miss; hit_o tag match; trigger_o descriptor request;
//   stride_o learned stride.
module bp_be_stride_detector_entry
  import bp_be_stride_detector_pkg::*;
 #(parameter int conf_thresh_p = 2
  ,parameter int prefetch_depth_p = 4)
  (input  logic clk_i
  ,input  logic reset_i
  ,input  logic flush_i
  ,input  logic obs_v_i
  ,input  logic [vaddr_width_gp-1:0] obs_pc_i
  ,input  logic [dpath_width_gp-1:0] obs_eff_addr_i
  ,input  logic alloc_i
  ,output logic hit_o
  ,output logic trigger_o
  ,output logic [stride_width_gp-1:0] stride_o);
  bp_be_stride_entry_s r;
  logic [dpath_width_gp-1:0] delta;
  logic legal, match, issued_n;
  logic [1:0] conf_n;
  logic [loop_range_gp-1:0] cd_n;
  always_comb begin
    hit_o = r.valid & (r.tag == obs_pc_i);
    // negative deltas wrap to huge unsigned values and so fail the range test
    delta = obs_eff_addr_i - r.last_addr;
    legal = (delta != '0) & (delta[dpath_width_gp-1:stride_width_gp] == '0);
    match = legal & (delta[stride_width_gp-1:0] == r.stride);
    conf_n = match ? conf_inc(r.conf) : 2'd0;
    issued_n = match & r.issued;
    cd_n = !match ? '0
         : (r.issued & (r.cooldown != '1)) ? r.cooldown + loop_range_gp'(1) : r.cooldown;
    trigger_o = obs_v_i & hit_o & (conf_n >= 2'(conf_thresh_p))
              & (!issued_n | (cd_n == loop_range_gp'(prefetch_depth_p)));
    stride_o = r.stride;
  end
  always_ff @(posedge clk_i)
    if (reset_i | flush_i)
      r <= '0;
    else if (obs_v_i & alloc_i)
      r <= '{valid: 1'b1, tag: obs_pc_i, last_addr: obs_eff_addr_i, default: '0};
    else if (obs_v_i & hit_o)
      r <= '{valid: 1'b1
            ,tag: r.tag
            ,last_addr: obs_eff_addr_i
            ,stride: match ? r.stride : legal ? delta[stride_width_gp-1:0] : '0
            ,conf: conf_n
            ,issued: issued_n | trigger_o
            ,cooldown: trigger_o ? '0 : cd_n};
endmodule

// File: rtl/bp_be_stride_detector.sv
// bp_be_stride_detector: learns per-PC constant positive strides from committed loads and emits prefetch descriptors
//   ports: clk_i, reset_i (sync, active-high), flush_i; obs_v_i/obs_pc_i/obs_eff_addr_i committed load;
//   v_o/ready_and_i descriptor handshake; pc_o, loop_counter_o, eff_addr_o, stride_o descriptor fields.
module bp_be_stride_detector
  import bp_be_stride_detector_pkg::*;
 #(parameter int entries_p = 8
  ,parameter int conf_thresh_p = 2
  ,parameter int prefetch_depth_p = 4)
  (input  logic clk_i
  ,input  logic reset_i
  ,input  logic flush_i
  ,input  logic obs_v_i
  ,input  logic [vaddr_width_gp-1:0] obs_pc_i
  ,input  logic [dpath_width_gp-1:0] obs_eff_addr_i
  ,output logic v_o
  ,input  logic ready_and_i
  ,output logic [vaddr_width_gp-1:0] pc_o
  ,output logic [loop_range_gp-1:0] loop_counter_o
  ,output logic [dpath_width_gp-1:0] eff_addr_o
  ,output logic [stride_width_gp-1:0] stride_o);
  localparam int ptr_w = $clog2(entries_p);
  logic [entries_p-1:0] hit, trig, alloc;
  logic [stride_width_gp-1:0] stride_v [entries_p];
  logic [stride_width_gp-1:0] stride_sel;
  logic [ptr_w-1:0] ptr;
  logic any_hit, any_trig;
  for (genvar i = 0; i < entries_p; i++) begin : e
    assign alloc[i] = ~any_hit & (ptr == ptr_w'(i));
    bp_be_stride_detector_entry #(.conf_thresh_p(conf_thresh_p), .prefetch_depth_p(prefetch_depth_p)) ent
      (.clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .obs_v_i(obs_v_i), .obs_pc_i(obs_pc_i)
      ,.obs_eff_addr_i(obs_eff_addr_i), .alloc_i(alloc[i]), .hit_o(hit[i]), .trigger_o(trig[i])
      ,.stride_o(stride_v[i]));
  end
  always_comb begin
    any_hit = |hit;
    any_trig = |trig;
    stride_sel = '0;
    for (int k = 0; k < entries_p; k++)
      stride_sel = stride_sel | (trig[k] ? stride_v[k] : '0);
  end
  assign loop_counter_o = loop_range_gp'(prefetch_depth_p);
  always_ff @(posedge clk_i)
    if (reset_i | flush_i)
      ptr <= '0;
    else if (obs_v_i & ~any_hit)
      ptr <= (ptr == ptr_w'(entries_p-1)) ? '0 : ptr + ptr_w'(1);
  // single output slot; a trigger arriving while it is full and not draining is dropped
  always_ff @(posedge clk_i)
    if (reset_i) begin
      v_o <= 1'b0;
      pc_o <= '0;
      eff_addr_o <= '0;
      stride_o <= '0;
    end else if (flush_i)
      v_o <= 1'b0;
    else if (any_trig & (~v_o | ready_and_i)) begin
      v_o <= 1'b1;
      pc_o <= obs_pc_i;
      eff_addr_o <= obs_eff_addr_i;
      stride_o <= stride_sel;
    end else if (ready_and_i)
      v_o <= 1'b0;
endmodule

// File: doc/bp_be_stride_detector.md
Name: bp_be_stride_detector

Overview:
- Trains on committed loads and, per load PC, learns a constant positive address stride.
- Once a PC's stride is confident, issues one striding-load descriptor (pc, base address, stride, prefetch count) over a valid/ready handshake.
- The consumer is the prefetch generator, which expands each descriptor into prefetch dispatch packets.
- Sits in bp_be_checker, fed from the commit path.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration (supplies vaddr_width_p, dpath_width_gp).
- entries_p, 8, number of fully associative PC-tagged training entries.
- loop_range_p, 8, width of loop_counter_o and of per-entry cooldown counter.
- stride_width_p, 8, width of the unsigned stride field.
- conf_thresh_p, 2, confidence (0..3) at which an entry may trigger.
- prefetch_depth_p, 4, value driven on loop_counter_o; also the re-trigger interval in matching hits.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate all entries and drop any pending descriptor.
- obs_v_i  in  1  a committed load is observed this cycle.
- obs_pc_i  in  vaddr_width_p  PC of the observed load.
- obs_eff_addr_i  in  dpath_width_gp  effective address of the observed load.
- v_o  out  1  descriptor valid.
- ready_and_i  in  1  consumer accepts the descriptor when v_o & ready_and_i.
- pc_o  out  vaddr_width_p  PC of the triggering load.
- loop_counter_o  out  loop_range_p  number of strides to prefetch; constant prefetch_depth_p.
- eff_addr_o  out  dpath_width_gp  address of the triggering observation.
- stride_o  out  stride_width_p  learned stride.

Behaviour:
- Clock and reset: single clock clk_i. reset_i is synchronous and active-high.
- Reset state:
  - all entries invalid; round-robin victim pointer = 0.
  - v_o = 0; pc_o, eff_addr_o and stride_o = 0.
- Entry fields: valid, pc tag (full vaddr), last_addr, stride, conf (2-bit, saturating at 3), issued, cooldown.
- Lookup: combinational CAM compare of obs_pc_i against all valid tags. At most one hit; allocation guarantees no duplicates.
- Delta: delta = obs_eff_addr_i - last_addr, computed full width.
  - delta is "legal" iff 0 < delta < 2^stride_width_p, i.e. positive, nonzero, and fits.
  - Negative, zero and oversized deltas are illegal.
- On obs_v_i with a miss:
  - Allocate at the victim pointer, overwriting any valid entry there.
  - New entry: tag = pc, last_addr = addr, stride = 0, conf = 0, issued = 0, cooldown = 0.
  - Pointer advances mod entries_p.
- On obs_v_i with a hit:
  - last_addr <= addr.
  - If delta is legal and delta == stride: conf <= sat(conf+1), and cooldown <= cooldown+1 (saturating) if issued.
  - Otherwise: stride <= (legal ? delta : 0), conf <= 0, issued <= 0, cooldown <= 0.
- Trigger condition: a hit where the post-update conf >= conf_thresh_p and either
  - issued == 0, or
  - post-update cooldown == prefetch_depth_p.
- On trigger:
  - Set issued = 1 and cooldown = 0.
  - Load the output register: pc_o = obs_pc_i, eff_addr_o = obs_eff_addr_i, stride_o = stride, v_o = 1.
  - Latency is 1 cycle: trigger observed in cycle N gives v_o in cycle N+1.
- Output register: a single slot, holding until v_o & ready_and_i.
  - If the slot is full and not draining in the trigger cycle, the trigger is dropped. The entry still updates, with issued = 1.
  - If the slot drains in the same cycle as a new trigger, the new descriptor loads (back-to-back, no bubble).
- Same-PC observations on consecutive cycles must see the previous update; the table is written at the clock edge and there is no bypass hazard.
- flush_i:
  - All entries invalid, victim pointer = 0, v_o = 0 next cycle.
  - flush_i has priority over a same-cycle observation, which is ignored.
- reset_i mid-operation: same effect as flush_i, with highest priority.
- At most one observation per cycle. obs_* are ignored when obs_v_i = 0.

Decomposition:
- Shared package bp_be_pkg: add the bp_be_stride_entry_s struct (widths via a declare macro in bp_be_defines.svh) and the confidence max constant (2'b11).
- Natural sub-module: bp_be_stride_detector_entry, one entry's update/compare logic, instantiated entries_p times. The top holds the CAM hit vector, the round-robin pointer and the output register.
- Reuse bsg_circular_ptr for the victim pointer.

Test Plan:
- Basic training: PC 0x80000100 with addresses 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles, ready_and_i = 1. Exactly one v_o pulse, the cycle after the 4th observation, carrying pc_o = 0x80000100, eff_addr_o = 0x1018, stride_o = 8, loop_counter_o = 4.
- Re-trigger: continue the same PC with 0x1020 … 0x1038 (4 more matching hits). A second descriptor appears after 0x1038, with eff_addr_o = 0x1038.
- Stride break:
  - After training, observe 0x2000: no trigger, stride reset.
  - Then 0x2010, 0x2020, 0x2030: trigger after 0x2030 with stride_o = 0x10.
  - Negative sequence 0x3000, 0x2FF8, …: never triggers.
- Backpressure: hold ready_and_i = 0 while two trained PCs trigger.
  - The first descriptor holds stable; the second is dropped.
  - Raising ready_and_i on the cycle the second PC triggers again gives back-to-back descriptors.
- Replacement: with entries_p = 8, observe 9 distinct PCs. The 9th evicts entry 0, and PC #1 retrains from conf 0, needing 4 observations.
- Flush/reset: assert flush_i while v_o = 1 and a same-cycle observation is present. Next cycle v_o = 0, the observation is ignored, and all PCs require full retraining. Repeat with reset_i.
